// File: rtl/fpu_pkg.sv
// Shared FPU definitions: widths, exception flag positions and the
// writeback result entry carried through the result buffer.
package fpu_pkg;

    localparam int XLEN       = 32;
    localparam int FLAGW      = 5;
    localparam int RDW        = 5;
    localparam int FIFO_DEPTH = 2;

    // Exception flag bit positions inside a FLAGW-wide flag vector.
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic [FLAGW-1:0] flags;
        logic [RDW-1:0]   rd;
        logic             to_int;
    } res_entry_t;

    // Occupancy of the 2-entry buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/fpu_res_fifo.sv
// Two-entry registered FIFO of result entries. Occupancy is held as an
// explicit state (EMPTY/ONE/FULL) and exported for observation. The head
// entry is always driven from storage, so there is no input-to-output path.
module fpu_res_fifo
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  res_entry_t  push_entry,
    input  logic        pop,
    output res_entry_t  head,
    output fifo_state_e state,
    output logic        full,
    output logic        empty
);

    res_entry_t  mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    fifo_state_e state_q;
    fifo_state_e state_d;
    logic        do_push;
    logic        do_pop;

    // A push into a full buffer or a pop from an empty one is ignored.
    assign do_push = push && (state_q != FIFO_FULL);
    assign do_pop  = pop  && (state_q != FIFO_EMPTY);

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FIFO_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy: push-only +1, pop-only -1, push+pop unchanged.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FIFO_EMPTY: if (do_push) state_d = FIFO_ONE;
            FIFO_ONE: begin
                if (do_push && !do_pop)      state_d = FIFO_FULL;
                else if (do_pop && !do_push) state_d = FIFO_EMPTY;
            end
            FIFO_FULL:  if (do_pop) state_d = FIFO_ONE;
            default:    state_d = FIFO_EMPTY;
        endcase
    end

    // Storage and single-bit pointers; a 1-bit pointer wraps 1->0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign state = state_q;
    assign full  = (state_q == FIFO_FULL);
    assign empty = (state_q == FIFO_EMPTY);

endmodule

// File: rtl/fpu_wb_stage.sv
// FPU writeback stage: arbitrates the single-cycle and multi-cycle result
// sources into a 2-entry buffer feeding the register-file write port, and
// accumulates sticky exception flags as results commit.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Source readies depend only on registered occupancy (and, for
// the single-cycle source, on mc_valid_i), never on wb_ready_i. wb_valid_o
// and the wb_* payload stay stable until the transfer happens.
module fpu_wb_stage
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sc_valid_i,
    output logic             sc_ready_o,
    input  logic [XLEN-1:0]  sc_data_i,
    input  logic [FLAGW-1:0] sc_flags_i,
    input  logic [RDW-1:0]   sc_rd_i,
    input  logic             sc_to_int_i,
    input  logic             mc_valid_i,
    output logic             mc_ready_o,
    input  logic [XLEN-1:0]  mc_data_i,
    input  logic [FLAGW-1:0] mc_flags_i,
    input  logic [RDW-1:0]   mc_rd_i,
    input  logic             mc_to_int_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [XLEN-1:0]  wb_data_o,
    output logic [RDW-1:0]   wb_rd_o,
    output logic             wb_to_int_o,
    output logic [FLAGW-1:0] fflags_o,
    input  logic             fflags_wr_i,
    input  logic [FLAGW-1:0] fflags_wdata_i,
    output logic             busy_o
);

    res_entry_t  push_entry;
    res_entry_t  head;
    fifo_state_e fifo_state;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push_mc;
    logic        push_sc;
    logic        push;
    logic        pop;
    logic [FLAGW-1:0] fflags_q;

    // Multi-cycle results have priority; readies are held low during reset.
    assign mc_ready_o = rst_n && !fifo_full;
    assign sc_ready_o = rst_n && !fifo_full && !mc_valid_i;

    assign push_mc = mc_valid_i && mc_ready_o;
    assign push_sc = sc_valid_i && sc_ready_o;
    assign push    = push_mc || push_sc;
    assign pop     = wb_valid_o && wb_ready_i;

    // Select the payload of whichever source wins this cycle.
    always_comb begin
        push_entry = '{data: sc_data_i, flags: sc_flags_i, rd: sc_rd_i, to_int: sc_to_int_i};
        if (push_mc) begin
            push_entry = '{data: mc_data_i, flags: mc_flags_i, rd: mc_rd_i, to_int: mc_to_int_i};
        end
    end

    fpu_res_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .state      (fifo_state),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign wb_valid_o  = !fifo_empty;
    assign busy_o      = (fifo_state != FIFO_EMPTY);
    assign wb_data_o   = head.data;
    assign wb_rd_o     = head.rd;
    assign wb_to_int_o = head.to_int;

    // Sticky flags: a CSR write replaces the value, and a committing result
    // in the same cycle ORs its flags on top of the written value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fflags_q <= '0;
        end else begin
            fflags_q <= (fflags_wr_i ? fflags_wdata_i : fflags_q) | (pop ? head.flags : '0);
        end
    end

    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Directed bench for fpu_wb_stage: a vector table for the main sequence plus
// hand-written sequences for stall, throughput and mid-operation reset.
module tb_fpu_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        sc_valid_i;
    logic        sc_ready_o;
    logic [31:0] sc_data_i;
    logic [4:0]  sc_flags_i;
    logic [4:0]  sc_rd_i;
    logic        sc_to_int_i;
    logic        mc_valid_i;
    logic        mc_ready_o;
    logic [31:0] mc_data_i;
    logic [4:0]  mc_flags_i;
    logic [4:0]  mc_rd_i;
    logic        mc_to_int_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_to_int_o;
    logic [4:0]  fflags_o;
    logic        fflags_wr_i;
    logic [4:0]  fflags_wdata_i;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    fpu_wb_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sc_valid_i     (sc_valid_i),
        .sc_ready_o     (sc_ready_o),
        .sc_data_i      (sc_data_i),
        .sc_flags_i     (sc_flags_i),
        .sc_rd_i        (sc_rd_i),
        .sc_to_int_i    (sc_to_int_i),
        .mc_valid_i     (mc_valid_i),
        .mc_ready_o     (mc_ready_o),
        .mc_data_i      (mc_data_i),
        .mc_flags_i     (mc_flags_i),
        .mc_rd_i        (mc_rd_i),
        .mc_to_int_i    (mc_to_int_i),
        .wb_valid_o     (wb_valid_o),
        .wb_ready_i     (wb_ready_i),
        .wb_data_o      (wb_data_o),
        .wb_rd_o        (wb_rd_o),
        .wb_to_int_o    (wb_to_int_o),
        .fflags_o       (fflags_o),
        .fflags_wr_i    (fflags_wr_i),
        .fflags_wdata_i (fflags_wdata_i),
        .busy_o         (busy_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sc_v;
        logic [31:0] sc_data;
        logic [4:0]  sc_flags;
        logic [4:0]  sc_rd;
        logic        sc_ti;
        logic        mc_v;
        logic [31:0] mc_data;
        logic [4:0]  mc_flags;
        logic [4:0]  mc_rd;
        logic        mc_ti;
        logic        wb_rdy;
        logic        fw;
        logic [4:0]  fwd;
        logic        e_sc_rdy;
        logic        e_mc_rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_rd;
        logic        e_ti;
        logic [4:0]  e_fflags;
        logic        e_busy;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        sc_valid_i = 0; sc_data_i = '0; sc_flags_i = '0; sc_rd_i = '0; sc_to_int_i = 0;
        mc_valid_i = 0; mc_data_i = '0; mc_flags_i = '0; mc_rd_i = '0; mc_to_int_i = 0;
        wb_ready_i = 0; fflags_wr_i = 0; fflags_wdata_i = '0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check_head(input string tag, input logic [31:0] d, input logic [4:0] rd, input logic ti);
        chk({tag, ".valid"}, 32'(wb_valid_o), 32'd1);
        chk({tag, ".data"}, wb_data_o, d);
        chk({tag, ".rd"}, 32'(wb_rd_o), 32'(rd));
        chk({tag, ".to_int"}, 32'(wb_to_int_o), 32'(ti));
    endtask

    initial begin
        // rows: sc fields, mc fields, wb_rdy, fw, fwd | pre readies | post head, fflags, busy
        vecs[0]  = '{1, 32'h9,  5'h00, 5'd5, 1, 0, 32'h0,  5'h00, 5'd0, 0, 1, 0, 5'h00, 1, 1, 1, 32'h9,  5'd5, 1, 5'h00, 1};
        vecs[1]  = '{0, 32'h0,  5'h00, 5'd0, 0, 0, 32'h0,  5'h00, 5'd0, 0, 1, 0, 5'h00, 1, 1, 0, 32'h0,  5'd0, 0, 5'h00, 0};
        vecs[2]  = '{1, 32'hA0, 5'h00, 5'd1, 0, 1, 32'hB0, 5'h01, 5'd2, 0, 0, 0, 5'h00, 0, 1, 1, 32'hB0, 5'd2, 0, 5'h00, 1};
        vecs[3]  = '{1, 32'hA0, 5'h00, 5'd1, 0, 1, 32'hB1, 5'h00, 5'd3, 1, 0, 0, 5'h00, 0, 1, 1, 32'hB0, 5'd2, 0, 5'h00, 1};
        vecs[4]  = '{1, 32'hA0, 5'h00, 5'd1, 0, 1, 32'hB2, 5'h00, 5'd4, 1, 0, 0, 5'h00, 0, 0, 1, 32'hB0, 5'd2, 0, 5'h00, 1};
        vecs[5]  = '{1, 32'hA0, 5'h10, 5'd1, 0, 0, 32'h0,  5'h00, 5'd0, 0, 1, 0, 5'h00, 0, 0, 1, 32'hB1, 5'd3, 1, 5'h01, 1};
        vecs[6]  = '{1, 32'hA0, 5'h10, 5'd1, 0, 0, 32'h0,  5'h00, 5'd0, 0, 1, 0, 5'h00, 1, 1, 1, 32'hA0, 5'd1, 0, 5'h01, 1};
        vecs[7]  = '{0, 32'h0,  5'h00, 5'd0, 0, 0, 32'h0,  5'h00, 5'd0, 0, 1, 0, 5'h00, 1, 1, 0, 32'h0,  5'd0, 0, 5'h11, 0};
        vecs[8]  = '{1, 32'hC0FFEE00, 5'h04, 5'd7, 0, 0, 32'h0, 5'h00, 5'd0, 0, 0, 0, 5'h00, 1, 1, 1, 32'hC0FFEE00, 5'd7, 0, 5'h11, 1};
        vecs[9]  = '{0, 32'h0,  5'h00, 5'd0, 0, 0, 32'h0,  5'h00, 5'd0, 0, 1, 1, 5'h00, 1, 1, 0, 32'h0,  5'd0, 0, 5'h04, 0};
        vecs[10] = '{0, 32'h0,  5'h00, 5'd0, 0, 0, 32'h0,  5'h00, 5'd0, 0, 0, 1, 5'h08, 1, 1, 0, 32'h0,  5'd0, 0, 5'h08, 0};

        // Reset with a pending multi-cycle result: nothing may be accepted.
        drive_idle();
        rst_n = 0;
        mc_valid_i = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst.wb_data", wb_data_o, 32'd0);
        chk("rst.fflags", 32'(fflags_o), 32'd0);
        chk("rst.mc_ready", 32'(mc_ready_o), 32'd0);
        chk("rst.sc_ready", 32'(sc_ready_o), 32'd0);
        chk("rst.busy", 32'(busy_o), 32'd0);
        mc_valid_i = 0;
        rst_n = 1;
        #1;
        chk("rel.mc_ready", 32'(mc_ready_o), 32'd1);
        chk("rel.sc_ready", 32'(sc_ready_o), 32'd1);

        // Vector table: single push, priority/backpressure, flag accumulation.
        for (int i = 0; i < 11; i++) begin
            sc_valid_i = vecs[i].sc_v;   sc_data_i = vecs[i].sc_data; sc_flags_i = vecs[i].sc_flags;
            sc_rd_i    = vecs[i].sc_rd;  sc_to_int_i = vecs[i].sc_ti;
            mc_valid_i = vecs[i].mc_v;   mc_data_i = vecs[i].mc_data; mc_flags_i = vecs[i].mc_flags;
            mc_rd_i    = vecs[i].mc_rd;  mc_to_int_i = vecs[i].mc_ti;
            wb_ready_i = vecs[i].wb_rdy; fflags_wr_i = vecs[i].fw;    fflags_wdata_i = vecs[i].fwd;
            #1;
            chk($sformatf("v%0d.sc_ready", i), 32'(sc_ready_o), 32'(vecs[i].e_sc_rdy));
            chk($sformatf("v%0d.mc_ready", i), 32'(mc_ready_o), 32'(vecs[i].e_mc_rdy));
            step();
            chk($sformatf("v%0d.wb_valid", i), 32'(wb_valid_o), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d.wb_data", i), wb_data_o, vecs[i].e_data);
                chk($sformatf("v%0d.wb_rd", i), 32'(wb_rd_o), 32'(vecs[i].e_rd));
                chk($sformatf("v%0d.wb_to_int", i), 32'(wb_to_int_o), 32'(vecs[i].e_ti));
            end
            chk($sformatf("v%0d.fflags", i), 32'(fflags_o), 32'(vecs[i].e_fflags));
            chk($sformatf("v%0d.busy", i), 32'(busy_o), 32'(vecs[i].e_busy));
        end

        // Stall stability: one entry held for 4 cycles, then exactly one pop.
        drive_idle();
        mc_valid_i = 1; mc_data_i = 32'h3F800000; mc_rd_i = 5'd9; mc_to_int_i = 0;
        step();
        drive_idle();
        check_head("stall0", 32'h3F800000, 5'd9, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            step();
            check_head($sformatf("stall%0d", c), 32'h3F800000, 5'd9, 1'b0);
            chk($sformatf("stall%0d.busy", c), 32'(busy_o), 32'd1);
        end
        wb_ready_i = 1;
        step();
        chk("stall.drained", 32'(wb_valid_o), 32'd0);
        chk("stall.fflags", 32'(fflags_o), 32'h08);

        // Throughput: 8 back-to-back pushes, one pop per cycle, in order.
        for (int i = 0; i < 8; i++) begin
            sc_valid_i = 1; sc_data_i = 32'h100 + 32'(i); sc_rd_i = 5'(i); sc_to_int_i = 1;
            wb_ready_i = 1;
            #1;
            chk($sformatf("tp%0d.sc_ready", i), 32'(sc_ready_o), 32'd1);
            exp_q.push_back(32'h100 + 32'(i));
            step();
            chk($sformatf("tp%0d.wb_valid", i), 32'(wb_valid_o), 32'd1);
            if (exp_q.size() != 0) chk($sformatf("tp%0d.wb_data", i), wb_data_o, exp_q.pop_front());
        end
        drive_idle();
        wb_ready_i = 1;
        step();
        chk("tp.end_valid", 32'(wb_valid_o), 32'd0);
        chk("tp.queue_left", 32'(exp_q.size()), 32'd0);

        // Reset mid-operation discards a buffered result and clears flags.
        drive_idle();
        sc_valid_i = 1; sc_data_i = 32'h55; sc_rd_i = 5'd3;
        step();
        drive_idle();
        chk("mid.busy_before", 32'(busy_o), 32'd1);
        rst_n = 0;
        #1;
        chk("mid.wb_valid", 32'(wb_valid_o), 32'd0);
        chk("mid.wb_data", wb_data_o, 32'd0);
        chk("mid.busy", 32'(busy_o), 32'd0);
        chk("mid.fflags", 32'(fflags_o), 32'd0);
        chk("mid.mc_ready", 32'(mc_ready_o), 32'd0);
        step();
        rst_n = 1;
        step();
        chk("mid.after_valid", 32'(wb_valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
